xt_hb_master_arbiter: RTL and testbench
=======================================

// Module: xt_hb_master_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single XT_HB master port among several bus masters
//  (RISC-V core data port, future DMA, debug). It sits between the masters and XT_HB.
//  Per transaction it grants one master, forwards that master's read/write onto the bus,
//  and returns accept/stall per master. A watchdog aborts transfers that never finish.
// PARAMETERS
//  MASTER_NUM  2   number of requesting masters (>=2)
//  ADDR_W      32  width of raddr/waddr (HB_ADDR_WIDTH)
//  TIMEOUT     255 max BUSY cycles without m_done before abort (>=1, 0 = watchdog off)
// PORTS
//  hb_clk          in   1             bus clock; all logic on rising edge
//  rst_n           in   1             asynchronous, active-low reset
//  req_read        in   MASTER_NUM    per-master read request
//  req_write       in   MASTER_NUM    per-master write request
//  req_write_width in   [MASTER_NUM][2]       per-master write width (byte/half/word)
//  req_raddr       in   [MASTER_NUM][ADDR_W]  per-master read address
//  req_waddr       in   [MASTER_NUM][ADDR_W]  per-master write address
//  req_wdata       in   [MASTER_NUM][32]      per-master write data
//  read_accept     out  MASTER_NUM    1-cycle pulse: read completed, hb_rdata valid for that master
//  write_accept    out  MASTER_NUM    1-cycle pulse: write completed
//  stall_req       out  MASTER_NUM    master must hold its request and stall
//  abort_err       out  MASTER_NUM    1-cycle pulse: transfer aborted by watchdog
//  m_read          out  1             forwarded read to XT_HB
//  m_write         out  1             forwarded write to XT_HB
//  m_write_width   out  2             forwarded write width
//  m_raddr/m_waddr out  ADDR_W        forwarded addresses
//  m_wdata         out  32            forwarded write data
//  m_done          in   1             XT_HB: current transfer finished this cycle
//  grant_id        out  $clog2(MASTER_NUM)  currently granted master (debug/visibility)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, grant_id=0, last_grant=MASTER_NUM-1 (master 0 wins
//    first), watchdog count=0. All m_* outputs 0; all accept/abort pulses 0. stall_req=req
//    (read|write) per master, because no master is accepted during reset.
//  - req[i] = req_read[i] | req_write[i].
//  - IDLE: m_read=m_write=0. If any req, pick the first requester found searching
//    last_grant+1, last_grant+2, ... with wrap mod MASTER_NUM. Register grant_id,
//    last_grant <= winner, -> BUSY. If no req, stay IDLE.
//  - BUSY: m_* = request fields of master grant_id (registered grant, combinational mux).
//    A bus transfer starts at the earliest one cycle after the request is first seen.
//    - m_done=1: read_accept[g]=req_read[g], write_accept[g]=req_write[g] the same cycle.
//      A master asserting both read and write gets both accepts. -> IDLE (one idle bubble).
//    - Granted master drops req before m_done: m_* go 0 that cycle, no accept, -> IDLE.
//    - Watchdog: count increments every BUSY cycle without m_done. When count reaches
//      TIMEOUT: abort_err[g]=1 for one cycle, no accept, -> IDLE. Count clears on leaving BUSY.
//    - m_done and timeout in the same cycle: m_done wins, no abort.
//  - stall_req[i] = req[i] & ~(read_accept[i]|write_accept[i]|abort_err[i]). This is
//    combinational and includes the granted master while it waits for m_done.
//  - Masters hold address, data and width stable while stall_req is high (protocol rule).
//    The arbiter does not latch request payload.
//  - Fairness: with all masters requesting continuously, grants rotate 0,1,..,N-1,0,...
//    No master waits more than MASTER_NUM-1 transfers.
//  - Reset asserted mid-BUSY: transfer dropped immediately, no accept or abort pulse.
//    The master re-requests after reset.
// TESTING
//  1 Reset, then M0 read raddr=0x100 alone, m_done in 2nd BUSY cycle ->
//    m_read=1,m_raddr=0x100 one cycle after req; read_accept[0] pulses with m_done; stall_req[0] drops.
//  2 M0 and M1 request continuously, m_done every BUSY cycle -> grants 0,1,0,1;
//    accept cadence one transfer per 2 cycles.
//  3 M1 write wdata=0xDEADBEEF width=2 with M0 idle -> forwarded unchanged;
//    write_accept[1] only; stall_req[0]=0.
//  4 TIMEOUT=4, M0 read, m_done never -> abort_err[0] pulses after 4 BUSY cycles;
//    IDLE next; next grant goes to M1 if requesting.
//  5 m_done and timeout coincide -> read_accept pulses, abort_err stays 0.
//  6 rst_n low during BUSY -> outputs clear asynchronously; after release M0 is granted first.

Source files
------------

// File: rtl/xt_hb_master_arbiter.sv
// ----------------------------------------------------------------------------
// xt_hb_master_arbiter
//
// Purpose:
//   Round-robin arbiter sharing the single XT_HB master port among several bus
//   masters (core data port, DMA, debug). One master is granted per
//   transaction. Its request fields are forwarded onto the bus. Accept, stall
//   and abort are returned per master. A watchdog aborts transfers that never
//   see m_done.
//
// Ports:
//   hb_clk, rst_n     bus clock (rising edge) and asynchronous active-low reset
//   req_read/write    per-master read / write request          [MASTER_NUM]
//   req_write_width   per-master write width, 2 bits each        (flattened)
//   req_raddr/waddr   per-master addresses, ADDR_W bits each     (flattened)
//   req_wdata         per-master write data, 32 bits each        (flattened)
//   read_accept       pulse: read completed for that master
//   write_accept      pulse: write completed for that master
//   stall_req         master must hold its request and stall
//   abort_err         pulse: transfer aborted by the watchdog
//   m_read/m_write    forwarded read / write strobe to XT_HB
//   m_write_width     forwarded write width
//   m_raddr/m_waddr   forwarded addresses
//   m_wdata           forwarded write data
//   m_done            XT_HB: current transfer finished this cycle
//   grant_id          currently granted master
// ----------------------------------------------------------------------------
module xt_hb_master_arbiter #(
    parameter int MASTER_NUM = 2,
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                           hb_clk,
    input  logic                           rst_n,
    input  logic [MASTER_NUM-1:0]          req_read,
    input  logic [MASTER_NUM-1:0]          req_write,
    input  logic [2*MASTER_NUM-1:0]        req_write_width,
    input  logic [ADDR_W*MASTER_NUM-1:0]   req_raddr,
    input  logic [ADDR_W*MASTER_NUM-1:0]   req_waddr,
    input  logic [32*MASTER_NUM-1:0]       req_wdata,
    output logic [MASTER_NUM-1:0]          read_accept,
    output logic [MASTER_NUM-1:0]          write_accept,
    output logic [MASTER_NUM-1:0]          stall_req,
    output logic [MASTER_NUM-1:0]          abort_err,
    output logic                           m_read,
    output logic                           m_write,
    output logic [1:0]                     m_write_width,
    output logic [ADDR_W-1:0]              m_raddr,
    output logic [ADDR_W-1:0]              m_waddr,
    output logic [31:0]                    m_wdata,
    input  logic                           m_done,
    output logic [$clog2(MASTER_NUM)-1:0]  grant_id
);

    localparam int GW = $clog2(MASTER_NUM);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   last_next;
    logic [GW-1:0]   grant_next;
    logic [CW-1:0]   wd_count;
    logic [CW-1:0]   count_next;

    logic [MASTER_NUM-1:0] req;
    logic [GW-1:0]         winner;
    logic [GW-1:0]         cand;
    logic                  found;

    assign req = req_read | req_write;

    // Round-robin search starting just after the last winner; the first
    // requester found wins. Reset leaves last_grant at MASTER_NUM-1 so
    // master 0 is first in line.
    always_comb begin
        winner = last_grant;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= MASTER_NUM; k++) begin
            cand = GW'((int'(last_grant) + k) % MASTER_NUM);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(MASTER_NUM - 1);
            wd_count   <= '0;
        end else begin
            state      <= state_next;
            grant_id   <= grant_next;
            last_grant <= last_next;
            wd_count   <= count_next;
        end
    end

    // Next state and bus outputs. The payload is muxed from the registered
    // grant and is not latched: masters hold it stable while stalled.
    // The watchdog fires once wd_count (BUSY cycles without m_done so far)
    // has reached TIMEOUT; m_done in that cycle still takes priority.
    always_comb begin
        state_next    = state;
        grant_next    = grant_id;
        last_next     = last_grant;
        count_next    = wd_count;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_write_width = 2'b00;
        m_raddr       = '0;
        m_waddr       = '0;
        m_wdata       = '0;
        read_accept   = '0;
        write_accept  = '0;
        abort_err     = '0;
        case (state)
            IDLE: begin
                count_next = '0;
                if (found) begin
                    grant_next = winner;
                    last_next  = winner;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!req[grant_id]) begin
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    m_read        = req_read[grant_id];
                    m_write       = req_write[grant_id];
                    m_write_width = req_write_width[int'(grant_id)*2 +: 2];
                    m_raddr       = req_raddr[int'(grant_id)*ADDR_W +: ADDR_W];
                    m_waddr       = req_waddr[int'(grant_id)*ADDR_W +: ADDR_W];
                    m_wdata       = req_wdata[int'(grant_id)*32 +: 32];
                    if (m_done) begin
                        read_accept[grant_id]  = req_read[grant_id];
                        write_accept[grant_id] = req_write[grant_id];
                        state_next             = IDLE;
                        count_next             = '0;
                    end else if ((TIMEOUT != 0) && (wd_count == TIMEOUT_VAL)) begin
                        abort_err[grant_id] = 1'b1;
                        state_next          = IDLE;
                        count_next          = '0;
                    end else if (TIMEOUT != 0) begin
                        count_next = wd_count + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Every requester stalls until it receives an accept or an abort,
    // including the granted master while it waits for m_done.
    assign stall_req = req & ~(read_accept | write_accept | abort_err);

endmodule

// File: tb/tb_xt_hb_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_xt_hb_master_arbiter
//
// Purpose:
//   Self-checking bench for xt_hb_master_arbiter (2 masters, TIMEOUT=4).
//   A table of per-cycle vectors holds the request inputs and the
//   hand-computed outputs for single reads, alternating grants, a write,
//   a dropped request, simultaneous read+write, a watchdog abort and
//   m_done coinciding with the timeout. A hand-written sequence then covers
//   reset asserted in the middle of a transfer.
// ----------------------------------------------------------------------------
module tb_xt_hb_master_arbiter;

    logic        hb_clk;
    logic        rst_n;
    logic [1:0]  req_read;
    logic [1:0]  req_write;
    logic [3:0]  req_write_width;
    logic [63:0] req_raddr;
    logic [63:0] req_waddr;
    logic [63:0] req_wdata;
    logic [1:0]  read_accept;
    logic [1:0]  write_accept;
    logic [1:0]  stall_req;
    logic [1:0]  abort_err;
    logic        m_read;
    logic        m_write;
    logic [1:0]  m_write_width;
    logic [31:0] m_raddr;
    logic [31:0] m_waddr;
    logic [31:0] m_wdata;
    logic        m_done;
    logic [0:0]  grant_id;

    int tests_run;
    int tests_failed;

    xt_hb_master_arbiter #(
        .MASTER_NUM (2),
        .ADDR_W     (32),
        .TIMEOUT    (4)
    ) dut (
        .hb_clk          (hb_clk),
        .rst_n           (rst_n),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_write_width (req_write_width),
        .req_raddr       (req_raddr),
        .req_waddr       (req_waddr),
        .req_wdata       (req_wdata),
        .read_accept     (read_accept),
        .write_accept    (write_accept),
        .stall_req       (stall_req),
        .abort_err       (abort_err),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_write_width   (m_write_width),
        .m_raddr         (m_raddr),
        .m_waddr         (m_waddr),
        .m_wdata         (m_wdata),
        .m_done          (m_done),
        .grant_id        (grant_id)
    );

    initial hb_clk = 1'b0;
    always #5 hb_clk = ~hb_clk;

    typedef struct {
        logic [1:0] rr;
        logic [1:0] rw;
        logic       done;
        logic       mr;
        logic       mw;
        logic [1:0] ra;
        logic [1:0] wa;
        logic [1:0] st;
        logic [1:0] ab;
        logic       gid;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic [1:0] rr, input logic [1:0] rw, input logic done,
                          input logic mr, input logic mw, input logic [1:0] ra,
                          input logic [1:0] wa, input logic [1:0] st, input logic [1:0] ab,
                          input logic gid, input logic busy);
        vec_t v;
        v.rr = rr; v.rw = rw; v.done = done;
        v.mr = mr; v.mw = mw; v.ra = ra; v.wa = wa;
        v.st = st; v.ab = ab; v.gid = gid; v.busy = busy;
        vecs.push_back(v);
    endtask

    // Fixed per-master payload: M0 raddr 0x100, M1 raddr 0x200, etc.
    function automatic logic [97:0] expData(input logic busy, input logic gid);
        if (!busy)
            return '0;
        else if (gid == 1'b0)
            return {32'h0000_0100, 32'h0000_0300, 32'h1111_2222, 2'd0};
        else
            return {32'h0000_0200, 32'h0000_0400, 32'hDEAD_BEEF, 2'd2};
    endfunction

    function automatic logic [10:0] ctrlBundle();
        return {m_read, m_write, read_accept, write_accept, stall_req, abort_err, grant_id};
    endfunction

    function automatic logic [97:0] dataBundle();
        return {m_raddr, m_waddr, m_wdata, m_write_width};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge hb_clk);
        req_read  = v.rr;
        req_write = v.rw;
        m_done    = v.done;
        #1;
    endtask

    initial begin
        vec_t v;
        tests_run       = 0;
        tests_failed    = 0;
        rst_n           = 1'b0;
        req_read        = 2'b00;
        req_write       = 2'b00;
        m_done          = 1'b0;
        req_raddr       = {32'h0000_0200, 32'h0000_0100};
        req_waddr       = {32'h0000_0400, 32'h0000_0300};
        req_wdata       = {32'hDEAD_BEEF, 32'h1111_2222};
        req_write_width = {2'd2, 2'd0};

        //     rr     rw     dn    mr    mw    ra     wa     st     ab     gid   busy
        // reset state, then M0 single read completing in its 2nd BUSY cycle
        addVec(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        addVec(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        addVec(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1);
        addVec(2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        addVec(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        // both masters requesting, m_done every BUSY cycle: grants alternate
        addVec(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
        addVec(2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b1, 1'b1);
        addVec(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
        addVec(2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1);
        addVec(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
        addVec(2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b1, 1'b1);
        addVec(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        // M1 write 0xDEADBEEF width 2, M0 idle
        addVec(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0);
        addVec(2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 1'b1);
        addVec(2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1);
        addVec(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        // granted master drops its request before m_done
        addVec(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0);
        addVec(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        addVec(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        // simultaneous read and write from M0 gets both accepts
        addVec(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        addVec(2'b01, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1);
        addVec(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        // watchdog: 4 BUSY cycles without m_done, abort on the 5th, then M1
        addVec(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            addVec(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1);
        addVec(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01, 1'b0, 1'b1);
        addVec(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
        addVec(2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b1, 1'b1);
        // m_done on the same cycle the watchdog would fire: accept, no abort
        addVec(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            addVec(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1);
        addVec(2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        addVec(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

        repeat (3) @(negedge hb_clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v);
            checkOutput($sformatf("vec%0d_ctrl", i), 128'(ctrlBundle()),
                        128'({v.mr, v.mw, v.ra, v.wa, v.st, v.ab, v.gid}));
            checkOutput($sformatf("vec%0d_data", i), 128'(dataBundle()),
                        128'(expData(v.busy, v.gid)));
        end

        // Reset in the middle of an M1 transfer; M0 must win first afterwards.
        v = '{rr: 2'b10, rw: 2'b00, done: 1'b0, mr: 1'b0, mw: 1'b0, ra: 2'b00,
              wa: 2'b00, st: 2'b00, ab: 2'b00, gid: 1'b0, busy: 1'b0};
        applyStimulus(v);
        checkOutput("rst_pre_idle", 128'(ctrlBundle()), 128'(11'b0_0_00_00_10_00_0));
        applyStimulus(v);
        checkOutput("rst_pre_busy", 128'(ctrlBundle()), 128'(11'b1_0_00_00_10_00_1));
        #2;
        rst_n    = 1'b0;
        req_read = 2'b11;
        #1;
        checkOutput("rst_async_ctrl", 128'(ctrlBundle()), 128'(11'b0_0_00_00_11_00_0));
        checkOutput("rst_async_data", 128'(dataBundle()), 128'(0));
        @(posedge hb_clk);
        #1;
        checkOutput("rst_held", 128'(ctrlBundle()), 128'(11'b0_0_00_00_11_00_0));
        @(negedge hb_clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_release_idle", 128'(ctrlBundle()), 128'(11'b0_0_00_00_11_00_0));
        v.rr = 2'b11;
        applyStimulus(v);
        checkOutput("rst_first_grant", 128'(ctrlBundle()), 128'(11'b1_0_00_00_11_00_0));
        checkOutput("rst_first_data", 128'(dataBundle()), 128'(expData(1'b1, 1'b0)));
        v.done = 1'b1;
        applyStimulus(v);
        checkOutput("rst_first_accept", 128'(ctrlBundle()), 128'(11'b1_0_01_00_10_00_0));
        v.rr   = 2'b00;
        v.done = 1'b0;
        applyStimulus(v);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
